// File: rtl/seq_detect_param.sv
// seq_detect_param: serial pattern detector with loadable pattern, overlap and sticky modes.
// Define SEQ_DETECT_MATCH_CNT_EN to add the saturating match_cnt output.
module seq_detect_param #(
   parameter int PAT_W   = 4,
   parameter int OVERLAP = 1,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inp,
   input  logic             en,
   input  logic [PAT_W-1:0] pat,
   input  logic             load,
   input  logic             sticky,
   input  logic             clr,
`ifdef SEQ_DETECT_MATCH_CNT_EN
   output logic [CNT_W-1:0] match_cnt,
`endif
   output logic             ans
);
   localparam int FW = $clog2(PAT_W + 1);
   localparam logic [FW-1:0] FULL = FW'(PAT_W);
   typedef enum logic [1:0] {IDLE, HUNT, LATCHED} state_t;
   state_t state, state_n;
   logic [PAT_W-1:0] pat_reg, pat_n, hist, hist_n, hist_upd;
   logic [FW-1:0] fill, fill_n, fill_upd;
   logic ans_n, match, hit, restart;
   if (PAT_W < 2 || PAT_W > 16 || CNT_W < 1) begin : g_bad_param
      $error("seq_detect_param: PAT_W must be 2..16 and CNT_W >= 1");
   end
   always_comb begin
      hist_upd = {hist[PAT_W-2:0], inp};
      fill_upd = (fill == FULL) ? FULL : fill + 1'b1;
      match = (hist_upd == pat_reg) && (fill_upd == FULL);
      restart = load || (state != IDLE && clr);
      state_n = state;
      pat_n = pat_reg;
      hist_n = restart ? '0 : hist;
      fill_n = restart ? '0 : fill;
      ans_n = 1'b0;
      hit = 1'b0;
      if (load) begin
         pat_n = pat;
         state_n = HUNT;
      end else if (state != IDLE && clr) begin
         state_n = HUNT;
      end else if (state == LATCHED) begin
         ans_n = 1'b1;
      end else if (state == HUNT && en) begin
         hit = match;
         ans_n = match;
         hist_n = hist_upd;
         // a non-overlapping match restarts the bit count but keeps the shifted history
         fill_n = (match && OVERLAP == 0) ? '0 : fill_upd;
         state_n = (match && sticky) ? LATCHED : HUNT;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pat_reg <= '0;
         hist <= '0;
         fill <= '0;
         ans <= 1'b0;
      end else begin
         state <= state_n;
         pat_reg <= pat_n;
         hist <= hist_n;
         fill <= fill_n;
         ans <= ans_n;
      end
   end
`ifdef SEQ_DETECT_MATCH_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         match_cnt <= '0;
      else
         match_cnt <= restart ? '0 : (hit && !(&match_cnt)) ? match_cnt + 1'b1 : match_cnt;
   end
`endif
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: directed checks of seq_detect_param, overlap and non-overlap instances side by side.
module tb_seq_detect_param;
   logic clk, rst_n, inp, en, load, sticky, clr;
   logic [3:0] pat;
   logic ans, ans0;
   int n_chk, n_fail;
`ifdef SEQ_DETECT_MATCH_CNT_EN
   logic [1:0] cnt1, cnt0;
`endif
   seq_detect_param #(.PAT_W(4), .OVERLAP(1), .CNT_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .inp(inp), .en(en), .pat(pat), .load(load),
      .sticky(sticky), .clr(clr),
`ifdef SEQ_DETECT_MATCH_CNT_EN
      .match_cnt(cnt1),
`endif
      .ans(ans));
   seq_detect_param #(.PAT_W(4), .OVERLAP(0), .CNT_W(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .inp(inp), .en(en), .pat(pat), .load(load),
      .sticky(sticky), .clr(clr),
`ifdef SEQ_DETECT_MATCH_CNT_EN
      .match_cnt(cnt0),
`endif
      .ans(ans0));
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   task automatic drive(input logic b, input logic e);
      inp = b;
      en = e;
      @(posedge clk);
      #1;
   endtask
   task automatic do_load(input logic [3:0] p);
      load = 1'b1;
      pat = p;
      drive(1'b1, 1'b1);
      load = 1'b0;
      en = 1'b0;
   endtask
   task automatic test_reset;
      #3;
      n_chk++;
      if (ans !== 1'b0 || ans0 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ans: got %b/%b expected 0/0", ans, ans0);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      // pat_reg is 0 here, so a zero stream would match if IDLE were not honoured
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'b1);
         n_chk++;
         if (ans !== 1'b0 || ans0 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ans bit%0d: got %b/%b expected 0/0", i, ans, ans0);
         end
      end
   endtask
   task automatic test_overlap;
      logic [6:0] s = 7'b1001001, e1 = 7'b0001001, e0 = 7'b0001000;
      do_load(4'b1001);
      sticky = 1'b0;
      for (int i = 6; i >= 0; i--) begin
         drive(s[i], 1'b1);
         n_chk++;
         if (ans !== e1[i] || ans0 !== e0[i]) begin
            n_fail++;
            $display("FAIL overlap bit%0d: got %b/%b expected %b/%b", 7 - i, ans, ans0, e1[i], e0[i]);
         end
      end
   endtask
   task automatic test_no_overlap;
      logic [10:0] s = 11'b10010011001, e1 = 11'b00010010001, e0 = 11'b00010000001;
      do_load(4'b1001);
      for (int i = 10; i >= 0; i--) begin
         drive(s[i], 1'b1);
         n_chk++;
         if (ans !== e1[i] || ans0 !== e0[i]) begin
            n_fail++;
            $display("FAIL no_overlap bit%0d: got %b/%b expected %b/%b", 11 - i, ans, ans0, e1[i], e0[i]);
         end
      end
   endtask
   task automatic test_en_gap;
      logic [7:0] s = 8'b11010011, e = 8'b10001110, x = 8'b00000010;
      do_load(4'b1001);
      for (int i = 7; i >= 0; i--) begin
         drive(s[i], e[i]);
         n_chk++;
         if (ans !== x[i] || ans0 !== x[i]) begin
            n_fail++;
            $display("FAIL en_gap step%0d: got %b/%b expected %b", 7 - i, ans, ans0, x[i]);
         end
      end
   endtask
   task automatic test_sticky;
      logic [7:0] s = 8'b10010000, x = 8'b00011111;
      logic [3:0] s2 = 4'b1001, x2 = 4'b0001;
      do_load(4'b1001);
      sticky = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         drive(s[i], 1'b1);
         n_chk++;
         if (ans !== x[i] || ans0 !== x[i]) begin
            n_fail++;
            $display("FAIL sticky bit%0d: got %b/%b expected %b", 8 - i, ans, ans0, x[i]);
         end
      end
      sticky = 1'b0;
      drive(1'b0, 1'b0);
      drive(1'b1, 1'b1);
      n_chk++;
      if (ans !== 1'b1 || ans0 !== 1'b1) begin
         n_fail++;
         $display("FAIL sticky_hold: got %b/%b expected 1", ans, ans0);
      end
      clr = 1'b1;
      drive(1'b0, 1'b0);
      clr = 1'b0;
      n_chk++;
      if (ans !== 1'b0 || ans0 !== 1'b0) begin
         n_fail++;
         $display("FAIL sticky_clr: got %b/%b expected 0", ans, ans0);
      end
      for (int i = 3; i >= 0; i--) begin
         drive(s2[i], 1'b1);
         n_chk++;
         if (ans !== x2[i] || ans0 !== x2[i]) begin
            n_fail++;
            $display("FAIL after_clr bit%0d: got %b/%b expected %b", 4 - i, ans, ans0, x2[i]);
         end
      end
   endtask
   task automatic test_priority;
      logic [2:0] s = 3'b100;
      logic [3:0] s2 = 4'b0010;
      logic [6:0] s3 = 7'b1100110, x3 = 7'b0000001;
      for (int i = 2; i >= 0; i--) drive(s[i], 1'b1);
      clr = 1'b1;
      drive(1'b1, 1'b1);
      clr = 1'b0;
      n_chk++;
      if (ans !== 1'b0 || ans0 !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_over_en: got %b/%b expected 0", ans, ans0);
      end
      for (int i = 3; i >= 0; i--) begin
         drive(s2[i], 1'b1);
         n_chk++;
         if (ans !== 1'b0 || ans0 !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_flush bit%0d: got %b/%b expected 0", 4 - i, ans, ans0);
         end
      end
      load = 1'b1;
      clr = 1'b1;
      pat = 4'b0110;
      drive(1'b0, 1'b1);
      load = 1'b0;
      clr = 1'b0;
      for (int i = 6; i >= 0; i--) begin
         drive(s3[i], 1'b1);
         n_chk++;
         if (ans !== x3[i] || ans0 !== x3[i]) begin
            n_fail++;
            $display("FAIL load_prio bit%0d: got %b/%b expected %b", 7 - i, ans, ans0, x3[i]);
         end
      end
   endtask
   task automatic test_async_reset;
      logic [3:0] s = 4'b1001;
      logic [7:0] s2 = 8'b10010000;
      do_load(4'b1001);
      sticky = 1'b1;
      for (int i = 3; i >= 0; i--) drive(s[i], 1'b1);
      n_chk++;
      if (ans !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_latch: got %b expected 1", ans);
      end
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if (ans !== 1'b0 || ans0 !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: got %b/%b expected 0", ans, ans0);
      end
      @(posedge clk);
      #3 rst_n = 1'b1;
      sticky = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         drive(s2[i], 1'b1);
         n_chk++;
         if (ans !== 1'b0 || ans0 !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle bit%0d: got %b/%b expected 0", 8 - i, ans, ans0);
         end
      end
   endtask
`ifdef SEQ_DETECT_MATCH_CNT_EN
   task automatic test_cnt;
      logic [15:0] s = 16'b1001001001001001;
      int m = 0;
      do_load(4'b1001);
      sticky = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         drive(s[16-i], 1'b1);
         if (i >= 4 && (i - 4) % 3 == 0 && m < 3) m++;
         n_chk++;
         if (cnt1 !== 2'(m)) begin
            n_fail++;
            $display("FAIL match_cnt bit%0d: got %0d expected %0d", i, cnt1, m);
         end
      end
      do_load(4'b1001);
      n_chk++;
      if (cnt1 !== 2'd0) begin
         n_fail++;
         $display("FAIL match_cnt_load: got %0d expected 0", cnt1);
      end
   endtask
`endif
   initial begin
      n_chk = 0;
      n_fail = 0;
      rst_n = 1'b0;
      inp = 1'b0;
      en = 1'b0;
      load = 1'b0;
      sticky = 1'b0;
      clr = 1'b0;
      pat = 4'b0000;
      test_reset;
      test_overlap;
      test_no_overlap;
      test_en_gap;
      test_sticky;
      test_priority;
      test_async_reset;
`ifdef SEQ_DETECT_MATCH_CNT_EN
      test_cnt;
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
